// File: rtl/method_call_pkg.sv
// Shared types and defaults for the method-call initiator.
package method_call_pkg;

  localparam int unsigned DEFAULT_TIMEOUT = 100000;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    CALL,
    WAIT_DONE,
    DONE
  } state_e;

endpackage

// File: rtl/cycle_watchdog.sv
// Saturating cycle counter with an expiry flag for the incoming edge.
module cycle_watchdog
  import method_call_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  output logic [31:0] count,
  output logic        expired
);

  logic [32:0] count_inc;

  assign count_inc = {1'b0, count} + 33'd1;

  // Expired when the count about to be written reaches TIMEOUT.
  assign expired = enable && (count_inc >= 33'(TIMEOUT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/method_call_initiator.sv
// Fills a target array, issues one method request, and checks the return value.
module method_call_initiator
  import method_call_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RET_W   = 32,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] fill_count,
  input  logic [DATA_W-1:0] fill_base,
  output logic [DATA_W-1:0] arr_idx,
  output logic [DATA_W-1:0] arr_in,
  output logic              arr_we,
  output logic              m_req,
  input  logic              m_busy,
  input  logic [RET_W-1:0]  m_return,
  input  logic [RET_W-1:0]  expected,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [RET_W-1:0]  result,
  output logic [31:0]       cycles
);

  state_e            state;
  logic [DATA_W-1:0] fill_last;
  logic              start_ok;
  logic              busy_st;
  logic              wd_expired;

  assign start_ok = start && ((state == IDLE) || (state == DONE));
  assign busy_st  = (state == FILL) || (state == CALL) || (state == WAIT_DONE);

  cycle_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (start_ok),
    .enable (busy_st),
    .count  (cycles),
    .expired(wd_expired)
  );

  // Sequence control; timeout overrides any completion in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      fill_last <= '0;
      arr_idx   <= '0;
      arr_in    <= '0;
      arr_we    <= 1'b0;
      m_req     <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      result    <= '0;
    end else if (busy_st && wd_expired) begin
      state   <= DONE;
      arr_we  <= 1'b0;
      arr_idx <= '0;
      arr_in  <= '0;
      m_req   <= 1'b0;
      done    <= 1'b1;
      pass    <= 1'b0;
      timeout <= 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            fill_last <= fill_count - DATA_W'(1);
            if (fill_count == '0) begin
              state <= CALL;
              m_req <= 1'b1;
            end else begin
              state   <= FILL;
              arr_we  <= 1'b1;
              arr_idx <= '0;
              arr_in  <= fill_base;
            end
          end
        end
        FILL: begin
          if (arr_idx == fill_last) begin
            state   <= CALL;
            arr_we  <= 1'b0;
            arr_idx <= '0;
            arr_in  <= '0;
            m_req   <= 1'b1;
          end else begin
            arr_idx <= arr_idx + DATA_W'(1);
            arr_in  <= arr_in + DATA_W'(1);
          end
        end
        CALL: begin
          if (m_busy) begin
            state <= WAIT_DONE;
            m_req <= 1'b0;
          end
        end
        WAIT_DONE: begin
          if (!m_busy) begin
            state  <= DONE;
            result <= m_return;
            pass   <= (m_return == expected);
            done   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_method_call_initiator.sv
// Randomized bench for method_call_initiator against a transaction-level model.
module tb_method_call_initiator;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned RET_W   = 32;
  localparam int unsigned TIMEOUT = 50;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] fill_count = '0;
  logic [DATA_W-1:0] fill_base = '0;
  logic [DATA_W-1:0] arr_idx;
  logic [DATA_W-1:0] arr_in;
  logic              arr_we;
  logic              m_req;
  logic              m_busy = 1'b0;
  logic [RET_W-1:0]  m_return = '0;
  logic [RET_W-1:0]  expected = '0;
  logic              done;
  logic              pass;
  logic              timeout;
  logic [RET_W-1:0]  result;
  logic [31:0]       cycles;

  int checks = 0;
  int failures = 0;

  method_call_initiator #(
    .DATA_W (DATA_W),
    .RET_W  (RET_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .fill_count(fill_count),
    .fill_base (fill_base),
    .arr_idx   (arr_idx),
    .arr_in    (arr_in),
    .arr_we    (arr_we),
    .m_req     (m_req),
    .m_busy    (m_busy),
    .m_return  (m_return),
    .expected  (expected),
    .done      (done),
    .pass      (pass),
    .timeout   (timeout),
    .result    (result),
    .cycles    (cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Behavioural model: a call is active from an accepted start until done;
  // it first writes fill_count entries, then waits for an ack, then for busy to fall.
  logic        mdl_active = 1'b0;
  logic [31:0] elapsed = '0;
  logic [31:0] wleft = '0;
  logic [31:0] widx = '0;
  logic [31:0] wbase = '0;
  logic        acked = 1'b0;
  logic        e_we = 1'b0, e_req = 1'b0, e_done = 1'b0, e_pass = 1'b0, e_to = 1'b0;
  logic [31:0] e_res = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mdl_active = 1'b0; elapsed = '0; wleft = '0; widx = '0; wbase = '0; acked = 1'b0;
      e_we = 1'b0; e_req = 1'b0; e_done = 1'b0; e_pass = 1'b0; e_to = 1'b0; e_res = '0;
    end else if (!mdl_active) begin
      if (start) begin
        mdl_active = 1'b1;
        e_done = 1'b0; e_pass = 1'b0; e_to = 1'b0;
        elapsed = '0; wleft = fill_count; widx = '0; wbase = fill_base; acked = 1'b0;
        e_we  = (fill_count != '0);
        e_req = (fill_count == '0);
      end
    end else begin
      if (elapsed != 32'hFFFF_FFFF) elapsed = elapsed + 32'd1;
      if (elapsed >= TIMEOUT) begin
        mdl_active = 1'b0; e_done = 1'b1; e_to = 1'b1; e_pass = 1'b0; e_we = 1'b0; e_req = 1'b0;
      end else if (wleft != '0) begin
        wleft = wleft - 32'd1;
        if (wleft == '0) begin
          e_we = 1'b0; e_req = 1'b1;
        end else begin
          widx = widx + 32'd1;
        end
      end else if (!acked) begin
        if (m_busy) begin
          acked = 1'b1; e_req = 1'b0;
        end
      end else if (!m_busy) begin
        mdl_active = 1'b0; e_done = 1'b1; e_res = m_return; e_pass = (m_return == expected);
      end
    end
  end

  logic [31:0] wq_idx[$];
  logic [31:0] wq_dat[$];
  int          req_cycles = 0;

  // Compare DUT against the model one time unit after every rising edge.
  always @(posedge clk) begin
    #1;
    check("done", 64'(done), 64'(e_done));
    check("pass", 64'(pass), 64'(e_pass));
    check("timeout", 64'(timeout), 64'(e_to));
    check("result", 64'(result), 64'(e_res));
    check("cycles", 64'(cycles), 64'(elapsed));
    check("arr_we", 64'(arr_we), 64'(e_we));
    check("m_req", 64'(m_req), 64'(e_req));
    check("we_req_excl", 64'(arr_we & m_req), 64'(0));
    if (e_we) begin
      check("arr_idx", 64'(arr_idx), 64'(widx));
      check("arr_in", 64'(arr_in), 64'(32'(wbase + widx)));
    end
    if (arr_we) begin
      wq_idx.push_back(arr_idx);
      wq_dat.push_back(arr_in);
    end
    if (m_req) req_cycles++;
  end

  // Target BFM, stepped once per falling edge from the stimulus process.
  int tgt_phase = 2, tgt_cnt = 0, tgt_delay = 1, tgt_len = 1;
  bit tgt_never = 1'b0;

  task automatic tgt_step();
    case (tgt_phase)
      0: if (m_req) begin
        tgt_cnt++;
        if (!tgt_never && tgt_cnt >= tgt_delay) begin
          m_busy = 1'b1; tgt_phase = 1; tgt_cnt = 0;
        end
      end
      1: begin
        tgt_cnt++;
        if (tgt_cnt >= tgt_len) begin
          m_busy = 1'b0; tgt_phase = 2;
        end
      end
      default: ;
    endcase
  endtask

  task automatic tick();
    @(negedge clk);
    tgt_step();
  endtask

  task automatic run_txn(input int fc, input logic [31:0] base, input int dly, input int len,
                         input logic [31:0] ret, input logic [31:0] exp, input bit never,
                         input bit pre, input bit noise);
    int n;
    tick();
    fill_count = 32'(fc); fill_base = base; m_return = ret; expected = exp;
    tgt_delay = dly; tgt_len = len; tgt_never = never; tgt_cnt = 0;
    if (pre) begin
      m_busy = 1'b1; tgt_phase = 1;
    end else begin
      m_busy = 1'b0; tgt_phase = 0;
    end
    wq_idx.delete(); wq_dat.delete(); req_cycles = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 400) begin
      tick();
      n++;
      if (noise && (arr_we || m_req) && $urandom_range(0, 3) == 0) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        n++;
      end
    end
    check("done_wait", 64'(done), 64'(1));
    repeat (2) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit actual=expired required=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    reset = 1'b0;
    repeat (3) tick();
    check("rst_done", 64'(done), 64'(0));
    check("rst_cycles", 64'(cycles), 64'(0));
    check("rst_req", 64'(m_req), 64'(0));
    reset = 1'b1;
    repeat (2) tick();

    // Four writes of 10..13, then a request acked after 2 cycles, return after 20.
    run_txn(4, 32'd10, 2, 20, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
    check("fill_len", 64'(wq_idx.size()), 64'(4));
    for (int i = 0; i < 4 && i < wq_idx.size(); i++) begin
      check("fill_idx", 64'(wq_idx[i]), 64'(i));
      check("fill_dat", 64'(wq_dat[i]), 64'(10 + i));
    end
    check("req_len", 64'(req_cycles), 64'(2));
    check("ok_done", 64'(done), 64'(1));
    check("ok_pass", 64'(pass), 64'(1));
    check("ok_result", 64'(result), 64'(1));
    check("ok_cycles_near26", 64'((cycles >= 32'd25) && (cycles <= 32'd27)), 64'(1));

    // Wrong return value.
    run_txn(0, 32'd0, 1, 5, 32'd0, 32'd1, 1'b0, 1'b0, 1'b0);
    check("bad_done", 64'(done), 64'(1));
    check("bad_pass", 64'(pass), 64'(0));
    check("bad_timeout", 64'(timeout), 64'(0));

    // Target never acknowledges.
    run_txn(0, 32'd0, 1, 5, 32'd3, 32'd3, 1'b1, 1'b0, 1'b0);
    check("to_done", 64'(done), 64'(1));
    check("to_flag", 64'(timeout), 64'(1));
    check("to_cycles", 64'(cycles), 64'(50));
    check("to_req", 64'(m_req), 64'(0));
    check("to_pass", 64'(pass), 64'(0));

    // Busy already high on CALL entry.
    run_txn(0, 32'd0, 1, 5, 32'd7, 32'd7, 1'b0, 1'b1, 1'b0);
    check("pre_req_len", 64'(req_cycles), 64'(1));
    check("pre_pass", 64'(pass), 64'(1));
    check("pre_result", 64'(result), 64'(7));

    // Reset during FILL at index 2.
    tick();
    fill_count = 32'd6; fill_base = 32'd100; tgt_phase = 0; tgt_delay = 1; tgt_len = 3;
    tgt_never = 1'b0; m_busy = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(arr_we && arr_idx == 32'd2) && n < 20) begin
      tick();
      n++;
    end
    check("reached_idx2", 64'(arr_we && arr_idx == 32'd2), 64'(1));
    #2 reset = 1'b0;
    #1;
    check("ar_we", 64'(arr_we), 64'(0));
    check("ar_idx", 64'(arr_idx), 64'(0));
    check("ar_in", 64'(arr_in), 64'(0));
    check("ar_req", 64'(m_req), 64'(0));
    check("ar_done", 64'(done), 64'(0));
    check("ar_result", 64'(result), 64'(0));
    check("ar_cycles", 64'(cycles), 64'(0));
    tgt_phase = 2; m_busy = 1'b0;
    req_cycles = 0; wq_idx.delete(); wq_dat.delete();
    repeat (2) tick();
    reset = 1'b1;
    repeat (5) tick();
    check("ar_no_req", 64'(req_cycles), 64'(0));
    check("ar_no_write", 64'(wq_idx.size()), 64'(0));
    run_txn(2, 32'd5, 1, 3, 32'd9, 32'd9, 1'b0, 1'b0, 1'b0);
    check("ar_after_pass", 64'(pass), 64'(1));

    // Data wraps modulo 2^32.
    run_txn(3, 32'hFFFF_FFFE, 1, 2, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    check("wrap_len", 64'(wq_dat.size()), 64'(3));
    if (wq_dat.size() == 3) check("wrap_dat2", 64'(wq_dat[2]), 64'(0));

    // Timeout while still filling.
    run_txn(100, 32'd0, 1, 2, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    check("fill_to", 64'(timeout), 64'(1));
    check("fill_to_writes", 64'(wq_idx.size()), 64'(50));

    for (int t = 0; t < 40; t++) begin
      run_txn(int'($urandom_range(0, 8)), $urandom, int'($urandom_range(1, 4)),
              int'($urandom_range(1, 25)), 32'($urandom_range(0, 3)), 32'($urandom_range(0, 3)),
              ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/method_call_initiator.md
METHOD_CALL_INITIATOR -- requirements
Module: method_call_initiator

Interface
REQ-001 SHALL have parameter DATA_W, default 32, array element and index width.
REQ-002 SHALL have parameter RET_W, default 32, method return width.
REQ-003 SHALL have parameter TIMEOUT, default 100000, max cycles from start to done.
REQ-004 SHALL have port clk, input, 1, sole clock, all state on rising edge.
REQ-005 SHALL have port reset, input, 1; asynchronous, active-low.
REQ-006 SHALL have port start, input, 1, one-cycle pulse that begins a call sequence.
REQ-007 SHALL have port fill_count, input, DATA_W, number of array entries to write before the call.
REQ-008 SHALL have port fill_base, input, DATA_W, data written to entry i is fill_base+i.
REQ-009 SHALL have ports arr_idx, arr_in (output, DATA_W each) and arr_we (output, 1): array write port to the target.
REQ-010 SHALL have port m_req, output, 1, method request to the target.
REQ-011 SHALL have port m_busy, input, 1, target busy.
REQ-012 SHALL have port m_return, input, RET_W, target return value.
REQ-013 SHALL have port expected, input, RET_W, value compared against the return.
REQ-014 SHALL have ports done, pass and timeout (output, 1 each) and result (output, RET_W).
REQ-015 SHALL have port cycles, output, 32, cycle count from start to done.

Function
REQ-016 SHALL implement FSM states IDLE, FILL, CALL, WAIT_DONE, DONE.
REQ-017 IDLE: start=1 SHALL go to FILL and clear done, pass, timeout and cycles; go directly to CALL if fill_count=0.
REQ-018 FILL: SHALL assert arr_we=1 for exactly fill_count consecutive cycles, with arr_idx=0..fill_count-1 and arr_in=fill_base+arr_idx (modulo 2^DATA_W), then go to CALL.
REQ-019 CALL: SHALL hold m_req=1 until m_busy=1 is sampled; m_req SHALL drop the following cycle and the FSM SHALL enter WAIT_DONE.
REQ-020 WAIT_DONE: on the first sampled m_busy=0, SHALL register m_return into result, set pass=(m_return==expected), and enter DONE.
REQ-021 DONE: SHALL hold done=1 and hold result/pass/timeout/cycles until the next start; start in DONE SHALL behave as in IDLE.
REQ-022 cycles SHALL increment every clock from the cycle after start until the DONE entry, saturating at 2^32-1.
REQ-023 If cycles reaches TIMEOUT in any of FILL, CALL or WAIT_DONE, SHALL enter DONE with timeout=1, pass=0, m_req=0 and arr_we=0.
REQ-024 A timeout and a completion in the same cycle SHALL resolve as timeout.
REQ-025 start outside IDLE/DONE SHALL be ignored.
REQ-026 m_busy already 1 on CALL entry SHALL count as acknowledge; m_req SHALL be high for exactly one cycle.
REQ-027 arr_we and m_req SHALL never be high in the same cycle.

Reset
REQ-028 reset=0 SHALL force IDLE asynchronously, with all outputs 0 (arr_idx, arr_in, result and cycles included).
REQ-029 Reset asserted mid-sequence SHALL abort it with no further writes or request; after release, the block SHALL wait in IDLE for a new start.

Structure
REQ-030 State encoding enum and default TIMEOUT constant SHALL live in shared package method_call_pkg.
REQ-031 The timeout/cycle counter SHALL be a sub-module cycle_watchdog (inputs clear and enable; outputs count and expired).
REQ-032 All outputs SHALL be registered; no combinational input-to-output path.

Verification
REQ-033 fill_count=4, fill_base=10 -> arr_we for 4 cycles, idx 0..3, data 10..13; then m_req pulse.
REQ-034 Target raises busy 2 cycles after req, returns 1 after 20 cycles, expected=1 -> done=1, pass=1, result=1, cycles within +/-1 of the model value.
REQ-035 Return 0, expected=1 -> done=1, pass=0, timeout=0.
REQ-036 Target never raises busy, TIMEOUT=50 -> done=1, timeout=1, cycles=50, m_req=0.
REQ-037 reset=0 during FILL at idx 2 -> all outputs 0 immediately, no m_req; after release a new start completes normally.
REQ-038 m_busy held at 1 before CALL; fill_count=0 -> m_req high for exactly one cycle, completion when busy falls.
